// File: rtl/irq_gateway_pkg.sv
// Shared configuration for the interrupt gateway: source count, counter width
// and the per-source state encoding.
package config_pkg;
  localparam int PLIC_NUM_SRC = 4;
  localparam int GW_CNTW      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } gw_state_e;
endpackage

// File: rtl/irq_gateway_src.sv
// One interrupt source: input synchronizer, rising-edge detect, saturating
// pending-edge counter and the IDLE/REQ/INSVC request state machine.
module irq_gateway_src
  import config_pkg::*;
#(
  parameter int CNTW = GW_CNTW
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic request,
  output logic overflow
);
  localparam logic [CNTW-1:0] CMAX = '1;

  logic            s1, s2, prev, mode_q;
  logic [CNTW-1:0] cnt, cnt_n;
  logic            ovf_n;
  gw_state_e       st, st_n;
  logic            rise, mode_chg, dec;

  assign rise     = s2 & ~prev;
  assign mode_chg = edge_mode ^ mode_q;
  assign dec      = (st == REQ) & claim;
  assign request  = (st == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      mode_q   <= 1'b0;
      cnt      <= '0;
      overflow <= 1'b0;
      st       <= IDLE;
    end else begin
      s1       <= src;
      s2       <= s1;
      prev     <= s2;
      mode_q   <= edge_mode;
      cnt      <= cnt_n;
      overflow <= ovf_n;
      st       <= st_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    ovf_n = overflow;
    if (mode_chg) begin
      // Mode switch flushes pending edges and withdraws an unclaimed request.
      cnt_n = '0;
      if (st == REQ) st_n = IDLE;
    end else if (edge_mode) begin
      // A claim frees a slot this cycle, so a coincident edge is never dropped.
      if (rise) begin
        if (cnt != CMAX || dec) cnt_n = cnt_n + 1'b1;
        else                    ovf_n = 1'b1;
      end
      if (dec) cnt_n = cnt_n - 1'b1;
      case (st)
        IDLE:    if (cnt_n != '0) st_n = REQ;
        REQ:     if (claim)       st_n = INSVC;
        INSVC:   if (complete)    st_n = IDLE;
        default:                  st_n = IDLE;
      endcase
    end else begin
      case (st)
        IDLE:    if (s2) st_n = REQ;
        REQ: begin
          if (claim)    st_n = INSVC;
          else if (!s2) st_n = IDLE;
        end
        INSVC:   if (complete) st_n = IDLE;
        default:               st_n = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/irq_gateway.sv
// PLIC interrupt gateway: decodes claim/complete IDs and fans them out to an
// array of per-source gateways.
module irq_gateway
  import config_pkg::*;
#(
  parameter int NSRC = PLIC_NUM_SRC,
  parameter int CNTW = GW_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] SrcIn,
  input  logic [NSRC-1:0] EdgeMode,
  input  logic            ClaimValid,
  input  logic [5:0]      ClaimID,
  input  logic            CompleteValid,
  input  logic [5:0]      CompleteID,
  output logic [NSRC-1:0] Request,
  output logic [NSRC-1:0] Overflow
);
  logic [NSRC-1:0] claim_hit, comp_hit;

  // ID 0 and IDs above NSRC match no instance and so fall away naturally.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    localparam logic [5:0] SRC_ID = 6'(g + 1);

    assign claim_hit[g] = ClaimValid    && (ClaimID    == SRC_ID);
    assign comp_hit[g]  = CompleteValid && (CompleteID == SRC_ID);

    irq_gateway_src #(.CNTW(CNTW)) u_src (
      .clk      (clk),
      .reset    (reset),
      .src      (SrcIn[g]),
      .edge_mode(EdgeMode[g]),
      .claim    (claim_hit[g]),
      .complete (comp_hit[g]),
      .request  (Request[g]),
      .overflow (Overflow[g])
    );
  end
endmodule

// File: tb/tb_irq_gateway.sv
// Self-checking bench for irq_gateway: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_irq_gateway;
  localparam int NSRC = 4;
  localparam int CNTW = 3;
  localparam int MAXC = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] SrcIn, EdgeMode;
  logic            ClaimValid, CompleteValid;
  logic [5:0]      ClaimID, CompleteID;
  logic [NSRC-1:0] Request, Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  irq_gateway #(.NSRC(NSRC), .CNTW(CNTW)) dut (
    .clk          (clk),
    .reset        (reset),
    .SrcIn        (SrcIn),
    .EdgeMode     (EdgeMode),
    .ClaimValid   (ClaimValid),
    .ClaimID      (ClaimID),
    .CompleteValid(CompleteValid),
    .CompleteID   (CompleteID),
    .Request      (Request),
    .Overflow     (Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // st: 0 idle, 1 requesting, 2 in service; cnt: pending edges (plain int).
  typedef struct {
    int st;
    int cnt;
    bit ovf;
  } mstate_t;

  mstate_t         m[NSRC];
  logic [NSRC-1:0] m_s1, m_s2, m_prev, m_mode;

  function automatic mstate_t step(mstate_t cur, bit lvl, bit rise, bit mode_old,
                                   bit mode_new, bit clm, bit cmp);
    mstate_t n = cur;
    bit      take;
    if (mode_new != mode_old) begin
      n.cnt = 0;
      if (cur.st == 1) n.st = 0;
    end else if (mode_new) begin
      take = (cur.st == 1) && clm;
      if (rise) begin
        if (cur.cnt < MAXC || take) n.cnt = n.cnt + 1;
        else                        n.ovf = 1'b1;
      end
      if (take) n.cnt = n.cnt - 1;
      if (cur.st == 0 && n.cnt > 0) n.st = 1;
      if (cur.st == 1 && clm)       n.st = 2;
      if (cur.st == 2 && cmp)       n.st = 0;
    end else begin
      if (cur.st == 0 && lvl)       n.st = 1;
      if (cur.st == 1)              n.st = clm ? 2 : (lvl ? 1 : 0);
      if (cur.st == 2 && cmp)       n.st = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) m[i] <= '{0, 0, 1'b0};
      m_s1   <= '0;
      m_s2   <= '0;
      m_prev <= '0;
      m_mode <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++)
        m[i] <= step(m[i], m_s2[i], m_s2[i] && !m_prev[i], m_mode[i], EdgeMode[i],
                     ClaimValid && (int'(ClaimID) == i + 1),
                     CompleteValid && (int'(CompleteID) == i + 1));
      m_s1   <= SrcIn;
      m_s2   <= m_s1;
      m_prev <= m_s2;
      m_mode <= EdgeMode;
    end
  end

  always @(posedge clk) begin
    int er, eo;
    #1;
    er = 0;
    eo = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (m[i].st == 1) er |= (1 << i);
      if (m[i].ovf)     eo |= (1 << i);
    end
    chk("model_request", int'(Request), er);
    chk("model_overflow", int'(Overflow), eo);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int i);
    SrcIn[i] = 1'b1;
    cyc(2);
    SrcIn[i] = 1'b0;
    cyc(2);
  endtask

  task automatic claim(input int id);
    ClaimValid = 1'b1;
    ClaimID    = 6'(id);
    cyc(1);
    ClaimValid = 1'b0;
    ClaimID    = '0;
  endtask

  task automatic complete(input int id);
    CompleteValid = 1'b1;
    CompleteID    = 6'(id);
    cyc(1);
    CompleteValid = 1'b0;
    CompleteID    = '0;
  endtask

  // Service source idx whenever it requests; counts requests seen (bounded waits).
  task automatic drain(input int idx, input int maxloops, output int n);
    n = 0;
    for (int k = 0; k < maxloops; k++) begin
      int w = 0;
      while (!Request[idx] && w < 8) begin
        cyc(1);
        w++;
      end
      if (!Request[idx]) break;
      n++;
      claim(idx + 1);
      complete(idx + 1);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    SrcIn = '0;
    EdgeMode = '0;
    ClaimValid = 1'b0;
    ClaimID = '0;
    CompleteValid = 1'b0;
    CompleteID = '0;
    cyc(2);
    chk("reset_request", int'(Request), 0);
    chk("reset_overflow", int'(Overflow), 0);
    reset = 1'b0;
    cyc(2);

    // Level source 1: 3-edge latency, claim, complete with line still high.
    SrcIn[0] = 1'b1;
    cyc(1); chk("lvl_lat_e0", int'(Request[0]), 0);
    cyc(1); chk("lvl_lat_e1", int'(Request[0]), 0);
    cyc(1); chk("lvl_lat_e2", int'(Request[0]), 1);
    claim(1);
    chk("lvl_claimed", int'(Request[0]), 0);
    cyc(3);
    chk("lvl_insvc_low", int'(Request[0]), 0);
    complete(1);
    chk("lvl_after_cmp", int'(Request[0]), 0);
    cyc(1);
    chk("lvl_rereq", int'(Request[0]), 1);
    SrcIn[0] = 1'b0;
    cyc(4);
    chk("lvl_drop", int'(Request[0]), 0);

    // Edge source 2: three pulses give exactly three requests.
    EdgeMode[1] = 1'b1;
    cyc(2);
    repeat (3) pulse(1);
    drain(1, 6, n);
    chk("edge_three_reqs", n, 3);
    chk("edge_drained", int'(Request[1]), 0);

    // Edge source 3: nine pulses saturate at 7 and set overflow.
    EdgeMode[2] = 1'b1;
    cyc(2);
    repeat (9) pulse(2);
    chk("sat_overflow", int'(Overflow), 4'b0100);
    drain(2, 10, n);
    chk("sat_seven_reqs", n, MAXC);
    chk("sat_ovf_sticky", int'(Overflow[2]), 1);

    // Edge source 4: edge coincident with claim keeps count at 1.
    EdgeMode[3] = 1'b1;
    cyc(2);
    pulse(3);
    chk("coin_req", int'(Request[3]), 1);
    SrcIn[3] = 1'b1;
    cyc(2);
    claim(4);
    SrcIn[3] = 1'b0;
    chk("coin_insvc", int'(Request[3]), 0);
    complete(4);
    chk("coin_idle", int'(Request[3]), 0);
    cyc(1);
    chk("coin_rereq", int'(Request[3]), 1);
    drain(3, 4, n);
    chk("coin_one_left", n, 1);

    // Ignored IDs: source 2 requesting, source 1 idle.
    pulse(1);
    chk("ign_pre", int'(Request), 4'b0010);
    claim(0);
    chk("ign_id0", int'(Request), 4'b0010);
    claim(63);
    chk("ign_id63", int'(Request), 4'b0010);
    claim(5);
    chk("ign_id5", int'(Request), 4'b0010);
    complete(1);
    complete(2);
    cyc(2);
    chk("ign_cmp_idle", int'(Request), 4'b0010);

    // Reset while source 2 is in service with five edges pending.
    repeat (5) pulse(1);
    claim(2);
    chk("rst_insvc", int'(Request), 0);
    reset = 1'b1;
    #1;
    chk("rst_async_req", int'(Request), 0);
    chk("rst_async_ovf", int'(Overflow), 0);
    cyc(2);
    reset = 1'b0;
    cyc(8);
    chk("rst_no_req", int'(Request), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 3) == 0) SrcIn[i] = ~SrcIn[i];
      if ($urandom_range(0, 199) == 0) begin
        int j = $urandom_range(0, NSRC - 1);
        EdgeMode[j] = ~EdgeMode[j];
      end
      ClaimValid    = ($urandom_range(0, 2) == 0);
      ClaimID       = 6'($urandom_range(0, 6));
      CompleteValid = ($urandom_range(0, 2) == 0);
      CompleteID    = 6'($urandom_range(0, 6));
      reset         = (c >= 1500 && c < 1502);
    end
    @(negedge clk);
    ClaimValid = 1'b0;
    CompleteValid = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_gateway.md
IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 Parameter NSRC, default PLIC_NUM_SRC (config_pkg), number of interrupt sources, range 1..63.
REQ-002 Parameter CNTW, default 3, width of each per-source edge pending counter.
REQ-003 clk  in  1  single block clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 SrcIn  in  NSRC  raw interrupt lines, asynchronous to clk; bit i-1 is source ID i.
REQ-006 EdgeMode  in  NSRC  per-source mode: 1 = rising-edge triggered, 0 = level triggered.
REQ-007 ClaimValid  in  1  one-cycle pulse from PLIC core: source ClaimID was claimed.
REQ-008 ClaimID  in  6  claimed source ID.
REQ-009 CompleteValid  in  1  one-cycle pulse from PLIC core: completion written.
REQ-010 CompleteID  in  6  completed source ID.
REQ-011 Request  out  NSRC  level request per source to the PLIC core pending logic.
REQ-012 Overflow  out  NSRC  sticky flag: an edge was dropped because the counter was saturated.

Function
REQ-013 Each SrcIn bit SHALL pass through a 2-flop synchronizer, then a third flop (prev) used for rising-edge detection (sync2 & ~prev).
REQ-014 Each source SHALL hold a state machine: IDLE, REQ, INSVC; Request[i] = (state == REQ), driven from registers only.
REQ-015 Level mode: IDLE->REQ when sync2 = 1; REQ->IDLE when sync2 = 0 and no claim; REQ->INSVC on matching claim; INSVC->IDLE on matching complete.
REQ-016 Edge mode: a detected edge SHALL increment the counter, saturating at 2^CNTW-1; IDLE->REQ when counter > 0.
REQ-017 Edge mode: matching claim in REQ SHALL decrement the counter and move to INSVC; matching complete SHALL move INSVC->IDLE, re-entering REQ on the next cycle if counter > 0.
REQ-018 Edge and claim on the same source in the same cycle: counter net unchanged; state -> INSVC.
REQ-019 Edge while counter saturated SHALL be dropped and SHALL set Overflow[i]; Overflow clears only on reset.
REQ-020 Latency: SrcIn rising (stable setup before edge 0) to Request high SHALL be exactly 3 clk edges from IDLE.
REQ-021 Claim for a source not in REQ, complete for a source not in INSVC, and ID 0 or ID > NSRC SHALL be ignored with no state change.
REQ-022 ClaimValid and CompleteValid in the same cycle with different IDs SHALL both take effect; with the same ID, only the applicable transition for the current state applies.
REQ-023 A change of EdgeMode[i] SHALL clear counter i next edge; state is unaffected, except REQ goes to IDLE.
REQ-024 Request[i] SHALL be low throughout INSVC regardless of SrcIn activity.

Reset
REQ-025 On reset assertion, asynchronously: synchronizers, prev flops, counters = 0; all states = IDLE; Request = 0; Overflow = 0.
REQ-026 Reset mid-service SHALL discard pending counts and in-service status; no Request until a new qualifying level or edge after deassertion.

Structure
REQ-027 The state enumeration (IDLE/REQ/INSVC) and CNTW default SHALL live in config_pkg; NSRC is taken from PLIC_NUM_SRC.
REQ-028 One sub-module irq_gateway_src (synchronizer, edge detect, counter, FSM for one source) SHALL be instantiated NSRC times in a generate loop; ID decode stays in the top level.

Verification
REQ-029 Level mode, SrcIn[0] held 1 -> Request[0] high after 3 edges; claim ID 1 -> Request[0] low next cycle; complete ID 1 with SrcIn still 1 -> Request[0] high 1 cycle after complete.
REQ-030 Edge mode, 3 pulses on source 2 -> counter 3; claim/complete loop repeated -> Request[1] asserts exactly 3 times, then stays low.
REQ-031 Edge mode CNTW = 3, 9 pulses with no claim -> counter 7, Overflow[i] = 1; 7 claim/complete cycles drain it; Overflow stays 1.
REQ-032 Edge coincident with claim on same source, counter = 1 -> state INSVC, counter stays 1; after complete, Request high again.
REQ-033 Claim ID 0, ID 63 (NSRC = 4), and complete for an IDLE source -> no state, counter or Request change.
REQ-034 reset asserted while source in INSVC with counter 5 -> Request = 0 and counter = 0 immediately; after deassertion, no Request without new stimulus.
